// File: rtl/tour_cmd_seq.sv
// Knight's tour command initiator.
// In IDLE the UART_wrapper command interface passes straight through to the
// command processor. A tour_go pulse hands the interface to the tour sequencer.
// The sequencer replays a memory of one-hot knight moves. Each move is issued
// as a vertical leg followed by a horizontal leg, and the block waits for
// send_resp after each leg. The response byte returned over BLE is also
// produced here.

module tour_cmd_seq #(
   parameter int NUM_MOVES = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tour_go,
   input  logic [7:0]  move,
   output logic [4:0]  mv_indx,
   input  logic [15:0] cmd_UART,
   input  logic        cmd_rdy_UART,
   output logic        clr_cmd_rdy_UART,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   output logic [7:0]  resp
);

   typedef enum logic [2:0] {
      IDLE,
      V_ISSUE,
      V_WAIT,
      H_ISSUE,
      H_WAIT
   } state_t;

   localparam logic [3:0] OP_VERT   = 4'h2;
   localparam logic [3:0] OP_HORZ   = 4'h3;
   localparam logic [7:0] HEAD_N    = 8'h00;
   localparam logic [7:0] HEAD_W    = 8'h3F;
   localparam logic [7:0] HEAD_S    = 8'h7F;
   localparam logic [7:0] HEAD_E    = 8'hBF;
   localparam logic [7:0] RESP_DONE = 8'hA5;
   localparam logic [7:0] RESP_BUSY = 8'h5A;
   localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

   state_t      state;
   state_t      nxt_state;
   logic [4:0]  nxt_indx;
   logic [2:0]  move_sel;
   logic [7:0]  v_heading;
   logic [3:0]  v_squares;
   logic [7:0]  h_heading;
   logic [3:0]  h_squares;
   logic [15:0] v_cmd;
   logic [15:0] h_cmd;
   logic        last_move;

   // State and move index registers. Asynchronous reset returns the block to pass-through.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         mv_indx <= 5'd0;
      end else begin
         state   <= nxt_state;
         mv_indx <= nxt_indx;
      end
   end

   // Priority-encode the move byte. The lowest set bit wins, and an all-zero byte acts as bit 0.
   always_comb begin
      move_sel = 3'd0;
      casez (move)
         8'b???????1: move_sel = 3'd0;
         8'b??????10: move_sel = 3'd1;
         8'b?????100: move_sel = 3'd2;
         8'b????1000: move_sel = 3'd3;
         8'b???10000: move_sel = 3'd4;
         8'b??100000: move_sel = 3'd5;
         8'b?1000000: move_sel = 3'd6;
         8'b10000000: move_sel = 3'd7;
         default:     move_sel = 3'd0;
      endcase
   end

   // Split the selected knight move into its vertical and horizontal legs.
   always_comb begin
      v_heading = HEAD_N;
      v_squares = 4'd2;
      h_heading = HEAD_E;
      h_squares = 4'd1;
      case (move_sel)
         3'd0: begin v_heading = HEAD_N; v_squares = 4'd2; h_heading = HEAD_E; h_squares = 4'd1; end
         3'd1: begin v_heading = HEAD_N; v_squares = 4'd2; h_heading = HEAD_W; h_squares = 4'd1; end
         3'd2: begin v_heading = HEAD_N; v_squares = 4'd1; h_heading = HEAD_W; h_squares = 4'd2; end
         3'd3: begin v_heading = HEAD_S; v_squares = 4'd1; h_heading = HEAD_W; h_squares = 4'd2; end
         3'd4: begin v_heading = HEAD_S; v_squares = 4'd2; h_heading = HEAD_W; h_squares = 4'd1; end
         3'd5: begin v_heading = HEAD_S; v_squares = 4'd2; h_heading = HEAD_E; h_squares = 4'd1; end
         3'd6: begin v_heading = HEAD_S; v_squares = 4'd1; h_heading = HEAD_E; h_squares = 4'd2; end
         3'd7: begin v_heading = HEAD_N; v_squares = 4'd1; h_heading = HEAD_E; h_squares = 4'd2; end
         default: begin v_heading = HEAD_N; v_squares = 4'd2; h_heading = HEAD_E; h_squares = 4'd1; end
      endcase
   end

   assign v_cmd     = {OP_VERT, v_heading, v_squares};
   assign h_cmd     = {OP_HORZ, h_heading, h_squares};
   assign last_move = (mv_indx == LAST_INDX);

   // Next-state and next-index logic. A consume strobe outranks a response in an issue state.
   always_comb begin
      nxt_state = state;
      nxt_indx  = mv_indx;
      case (state)
         IDLE: begin
            if (tour_go) begin
               nxt_state = V_ISSUE;
               nxt_indx  = 5'd0;
            end
         end
         V_ISSUE: begin
            if (clr_cmd_rdy) nxt_state = V_WAIT;
         end
         V_WAIT: begin
            if (send_resp) nxt_state = H_ISSUE;
         end
         H_ISSUE: begin
            if (clr_cmd_rdy) nxt_state = H_WAIT;
         end
         H_WAIT: begin
            if (send_resp) begin
               if (last_move) begin
                  nxt_state = IDLE;
                  nxt_indx  = 5'd0;
               end else begin
                  nxt_state = V_ISSUE;
                  nxt_indx  = mv_indx + 5'd1;
               end
            end
         end
         default: begin
            nxt_state = IDLE;
            nxt_indx  = 5'd0;
         end
      endcase
   end

   // Output decode. IDLE passes the UART interface through; touring states drive leg commands.
   // The command is held through WAIT so the processor still sees cmd[12] at the end of the move.
   always_comb begin
      cmd              = cmd_UART;
      cmd_rdy          = cmd_rdy_UART;
      clr_cmd_rdy_UART = clr_cmd_rdy;
      resp             = RESP_DONE;
      case (state)
         IDLE: begin
            cmd              = cmd_UART;
            cmd_rdy          = cmd_rdy_UART;
            clr_cmd_rdy_UART = clr_cmd_rdy;
            resp             = RESP_DONE;
         end
         V_ISSUE: begin
            cmd              = v_cmd;
            cmd_rdy          = 1'b1;
            clr_cmd_rdy_UART = 1'b0;
            resp             = RESP_BUSY;
         end
         V_WAIT: begin
            cmd              = v_cmd;
            cmd_rdy          = 1'b0;
            clr_cmd_rdy_UART = 1'b0;
            resp             = RESP_BUSY;
         end
         H_ISSUE: begin
            cmd              = h_cmd;
            cmd_rdy          = 1'b1;
            clr_cmd_rdy_UART = 1'b0;
            resp             = RESP_BUSY;
         end
         H_WAIT: begin
            cmd              = h_cmd;
            cmd_rdy          = 1'b0;
            clr_cmd_rdy_UART = 1'b0;
            resp             = last_move ? RESP_DONE : RESP_BUSY;
         end
         default: begin
            cmd              = cmd_UART;
            cmd_rdy          = cmd_rdy_UART;
            clr_cmd_rdy_UART = clr_cmd_rdy;
            resp             = RESP_DONE;
         end
      endcase
   end

endmodule

// File: doc/tour_cmd_seq.md
Name: tour_cmd_seq

Overview:
- Command initiator for the Knight's command processor. It sits between UART_wrapper and the command processor on the cmd/cmd_rdy/clr_cmd_rdy/send_resp interface.
- Idle: transparent pass-through of UART commands. On tour_go it takes ownership of the interface.
- Touring: replays an external move memory of one-hot knight moves. Each move is issued as a vertical leg followed by a horizontal leg, and the block waits for send_resp after each leg.
- Supplies the response byte returned over BLE.

Parameters:
- NUM_MOVES, 24, number of knight moves in a tour; mv_indx runs 0..NUM_MOVES-1 (max 32).

Ports:
- clk  in  1  system clock, 50MHz
- rst_n  in  1  reset; asynchronous, active-low
- tour_go  in  1  1-clk pulse, start tour
- move  in  8  one-hot knight move read from move memory at mv_indx
- mv_indx  out  5  move memory read index
- cmd_UART  in  16  command from UART_wrapper
- cmd_rdy_UART  in  1  UART command valid
- clr_cmd_rdy_UART  out  1  consume strobe forwarded to UART_wrapper
- cmd  out  16  command to processor
- cmd_rdy  out  1  command valid to processor
- clr_cmd_rdy  in  1  processor consumed cmd
- send_resp  in  1  processor finished current command
- resp  out  8  response byte to UART_wrapper

Behaviour:
- Reset:
  - Reset is rst_n, asynchronous, active-low; clock is clk.
  - On reset, state=IDLE and mv_indx=0.
  - Outputs then follow IDLE pass-through: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, resp=8'hA5.
- States: IDLE, V_ISSUE, V_WAIT, H_ISSUE, H_WAIT. All outputs are decoded from registered state (Moore), except the IDLE pass-through.
- IDLE:
  - cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy, resp=8'hA5.
  - tour_go: mv_indx<=0, then ->V_ISSUE. cmd_rdy is asserted the cycle after tour_go.
- Outside IDLE:
  - clr_cmd_rdy_UART=0 and cmd_rdy_UART is ignored. A UART command stays pending until the tour ends.
  - tour_go is ignored.
- V_ISSUE / H_ISSUE:
  - cmd_rdy=1 and cmd=leg command.
  - On clr_cmd_rdy, go to the matching WAIT state; cmd_rdy drops the next cycle.
  - send_resp in an ISSUE state is ignored.
- V_WAIT / H_WAIT:
  - cmd_rdy=0 and cmd is held unchanged, because the processor samples cmd[12] at the end of the move.
  - V_WAIT: send_resp -> H_ISSUE.
  - H_WAIT, send_resp with mv_indx==NUM_MOVES-1: mv_indx<=0, ->IDLE.
  - H_WAIT, send_resp otherwise: mv_indx<=mv_indx+1, ->V_ISSUE.
- resp outside IDLE:
  - 8'h5A for intermediate legs.
  - 8'hA5 while in H_WAIT of the final move.
- Command format: {opcode[3:0], heading[7:0], squares[3:0]}.
  - Vertical leg opcode = 4'h2.
  - Horizontal leg opcode = 4'h3 (fanfare plays at the end of each knight move).
  - Headings: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
- Move decode, bit: vertical leg, horizontal leg:
  - 0: N2, E1
  - 1: N2, W1
  - 2: N1, W2
  - 3: S1, W2
  - 4: S2, W1
  - 5: S2, E1
  - 6: S1, E2
  - 7: N1, E2
- Invalid move values:
  - Multi-hot: the lowest set bit wins.
  - All-zero: decodes as bit 0.
- move is decoded combinationally from mv_indx. mv_indx changes only on the H_WAIT->V_ISSUE or H_WAIT->IDLE transition, so cmd is stable per leg.
- Simultaneous events:
  - clr_cmd_rdy and send_resp in the same cycle in an ISSUE state: take the ISSUE->WAIT transition only.
- Reset mid-tour: immediate return to IDLE, mv_indx=0, cmd_rdy follows cmd_rdy_UART.

Test Plan:
- Pass-through: in IDLE, drive cmd_UART=16'h2003 with cmd_rdy_UART=1 -> cmd=16'h2003, cmd_rdy=1; clr_cmd_rdy=1 -> clr_cmd_rdy_UART=1; resp=8'hA5.
- Single move: move=8'h01, tour_go pulse -> next clk cmd=16'h2002, cmd_rdy=1; after clr_cmd_rdy and send_resp -> cmd=16'h3BF1; after clr_cmd_rdy and send_resp -> mv_indx=1.
- Full decode: step move through 8'h01..8'h80 -> vertical/horizontal pairs 2002/3BF1, 2002/33F1, 2001/33F2, 27F1/33F2, 27F2/33F1, 27F2/3BF1, 27F1/3BF2, 2001/3BF2.
- Tour completion (NUM_MOVES=3): run 6 leg handshakes -> resp=8'h5A on intermediate legs, 8'hA5 in final H_WAIT; then IDLE, mv_indx=0.
- Lockout: cmd_rdy_UART=1 and tour_go during V_WAIT -> cmd unchanged, cmd_rdy=0, clr_cmd_rdy_UART=0, state unaffected.
- Reset mid-tour in H_WAIT at mv_indx=5 -> mv_indx=0, IDLE pass-through active immediately; send_resp in V_ISSUE -> no transition.
